// File: rtl/conway_serial_pkg.sv
// Purpose : shared types and helpers for the Conway 1-bit serial link blocks.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Contents: link_state_e (IDLE/SHIFT) and cnt_width(), the bits-remaining counter width.
package conway_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } link_state_e;

    // The counter must hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/parallel_to_serial_if.sv
// Purpose : handshake and serial bus between a word source and parallel_to_serial.
// Latency : n/a (wires only).
// Backpr. : READY gates LOAD; HOLD stalls the serial side.
// Ports   : master = word source and serial consumer (drives DATA/LOAD/HOLD);
//           slave  = transmitter (drives READY/DATA_OUT/EN_OUT/DONE).
interface parallel_to_serial_if #(
    parameter int DEPTH = 8
);
    logic [DEPTH-1:0] DATA;
    logic             LOAD;
    logic             READY;
    logic             HOLD;
    logic             DATA_OUT;
    logic             EN_OUT;
    logic             DONE;

    modport master (
        output DATA, LOAD, HOLD,
        input  READY, DATA_OUT, EN_OUT, DONE
    );

    modport slave (
        input  DATA, LOAD, HOLD,
        output READY, DATA_OUT, EN_OUT, DONE
    );
endinterface

// File: rtl/parallel_to_serial.sv
// Purpose : serialises a DEPTH-bit word MSB first, one bit per enabled cycle.
// Latency : first bit valid the cycle after LOAD is accepted; DEPTH cycles per word plus HOLD cycles.
// Backpr. : READY low while a word is in flight (high on the last bit for back-to-back); HOLD stalls shifting.
// Ports   : CLK, RST (sync, active high), link (slave modport: DATA/LOAD/READY in,
//           HOLD stall in, DATA_OUT/EN_OUT serial out, DONE end-of-word pulse).
module parallel_to_serial
    import conway_serial_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    parallel_to_serial_if.slave  link
);

    localparam int CW = cnt_width(DEPTH);

    link_state_e       state_q;
    logic [DEPTH-1:0]  sreg_q;
    logic [CW-1:0]     count_q;
    logic              done_q;

    logic              xfer;
    logic              last_bit;
    logic              accept;

    // A bit is consumed at every edge where the link is shifting and not stalled.
    assign xfer     = (state_q == SHIFT) && !link.HOLD;
    assign last_bit = xfer && (count_q == CW'(1));
    // READY rises on the last bit so the next word loads with no idle bubble.
    assign accept   = link.LOAD && link.READY;

    assign link.DATA_OUT = sreg_q[DEPTH-1];
    assign link.EN_OUT   = xfer;
    assign link.READY    = (state_q == IDLE) || last_bit;
    assign link.DONE     = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            if (xfer) begin
                // Zero fill drains sreg, so DATA_OUT reads 0 once the word is gone.
                sreg_q  <= {sreg_q[DEPTH-2:0], 1'b0};
                count_q <= count_q - CW'(1);
                done_q  <= (count_q == CW'(1));
            end else if (state_q == IDLE) begin
                done_q  <= 1'b0;
            end
            // A stalled SHIFT state falls through: sreg, count and DONE hold.

            if (accept) begin
                sreg_q  <= link.DATA;
                count_q <= CW'(DEPTH);
                state_q <= SHIFT;
            end else if (last_bit) begin
                state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;

    localparam int DEPTH = 3;

    logic CLK = 1'b0;
    logic RST;

    parallel_to_serial_if #(.DEPTH(DEPTH)) lnk ();

    parallel_to_serial #(.DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .link (lnk)
    );

    always #5 CLK = ~CLK;

    // Reference receiver: shifts DATA_OUT in on every EN_OUT edge, MSB first.
    logic [DEPTH-1:0] rx_q;
    always_ff @(posedge CLK) begin
        if (RST)             rx_q <= '0;
        else if (lnk.EN_OUT) rx_q <= {rx_q[DEPTH-2:0], lnk.DATA_OUT};
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge, then stop at the falling edge so
    // checks see the values that the next rising edge will act on.
    task automatic cycle(input logic r, input logic l, input logic [DEPTH-1:0] d, input logic h);
        @(posedge CLK);
        #1;
        RST      = r;
        lnk.LOAD = l;
        lnk.DATA = d;
        lnk.HOLD = h;
        @(negedge CLK);
    endtask

    task automatic chk_out(input string tag, input logic dout, input logic en,
                           input logic rdy, input logic done);
        chk({tag, ".dout"},  8'(lnk.DATA_OUT), 8'(dout));
        chk({tag, ".en"},    8'(lnk.EN_OUT),   8'(en));
        chk({tag, ".ready"}, 8'(lnk.READY),    8'(rdy));
        chk({tag, ".done"},  8'(lnk.DONE),     8'(done));
    endtask

    initial begin
        RST      = 1'b1;
        lnk.LOAD = 1'b0;
        lnk.DATA = '0;
        lnk.HOLD = 1'b0;

        // 1. Reset wins over LOAD.
        cycle(1'b1, 1'b1, 3'b111, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("rst_idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // 2. Single word 101.
        cycle(1'b0, 1'b1, 3'b101, 1'b0);
        chk_out("w1_acc", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("w1_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("w1_b2", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("w1_b3", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("w1_done", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("w1_rx", 8'(rx_q), 8'h05);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("w1_post", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3. Word 110 with a two-cycle stall after the first bit.
        cycle(1'b0, 1'b1, 3'b110, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("h_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b1);
        chk_out("h_st1", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b1);
        chk_out("h_st2", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("h_b2", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("h_b3", 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("h_done", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("h_rx", 8'(rx_q), 8'h06);

        // 4. Back-to-back 101 then 011 with LOAD held high.
        cycle(1'b0, 1'b1, 3'b101, 1'b0);
        chk_out("bb_acc", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 3'b011, 1'b0);
        chk_out("bb_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b011, 1'b0);
        chk_out("bb_b2", 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b011, 1'b0);
        chk_out("bb_b3", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("bb_b4", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("bb_rx1", 8'(rx_q), 8'h05);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("bb_b5", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("bb_b6", 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("bb_done", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bb_rx2", 8'(rx_q), 8'h03);

        // 5. Loopback: receiver captures 101 and holds it while idle.
        cycle(1'b0, 1'b1, 3'b101, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 3'b000, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk("lb_done", 8'(lnk.DONE), 8'h01);
        chk("lb_rx", 8'(rx_q), 8'h05);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 3'b000, 1'b0);
            chk("lb_en_idle", 8'(lnk.EN_OUT), 8'h00);
            chk("lb_rx_hold", 8'(rx_q), 8'h05);
        end

        // 6. Mid-word reset; a LOAD while READY=0 must not be transmitted.
        cycle(1'b0, 1'b1, 3'b111, 1'b0);
        cycle(1'b0, 1'b1, 3'b010, 1'b0);
        chk_out("mr_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0);
        chk_out("mr_rst", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 3'b000, 1'b0);
            chk_out("mr_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
